half_buffer_fill_scheduler: RTL and testbench

//  Sequences the 256-word ARM->FPGA ping-pong buffer, split into half 0 (0x00-0x7F) and half 1 (0x80-0xFF).

---
 rtl/half_buffer_fill_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_half_buffer_fill_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/half_buffer_fill_scheduler.sv
// Ping-pong buffer scheduler: paces FPGA-side word reads across two 128-word halves,
// requests ARM refills of consumed halves and latches the first fault it sees.
module half_buffer_fill_scheduler #(
  parameter logic [15:0] READ_INTERVAL = 16'h0118,
  parameter logic [15:0] REQ_TIMEOUT   = 16'h4000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        enable,
  output logic [7:0]  addressAtBuffer,
  input  logic [31:0] dataAtBuffer,
  output logic [31:0] wordOut,
  output logic        wordValid,
  output logic        fillBuffer,
  output logic        fillHalf,
  input  logic        msgToFillBufferWasReceived,
  input  logic        fillDone,
  output logic        error,
  output logic [1:0]  errorCode
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_DONE = 2'b10,
    ERROR     = 2'b11
  } state_t;

  localparam logic [1:0] CODE_UNDERRUN = 2'b01;
  localparam logic [1:0] CODE_OVERRUN  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  state_t      state_r, stateNext_s;
  logic        sel_r, selNext_s;
  logic [1:0]  halfReady_r, halfReadyNext_s;
  logic [1:0]  pendingFill_r, pendingFillNext_s;
  logic        primed_r;
  logic [15:0] paceCnt_r;
  logic [15:0] timer_r, timerNext_s;
  logic [7:0]  addr_r;
  logic [31:0] wordOut_r;
  logic        wordValid_r;
  logic        fillBuffer_r;
  logic        fillHalf_r;
  logic        error_r;
  logic [1:0]  errorCode_r;

  logic        curHalf_s;
  logic        pacerRun_s;
  logic        terminal_s;
  logic        readOk_s;
  logic        underrun_s;
  logic        leaveHalf_s;
  logic        doneOk_s;
  logic        overrun_s;
  logic        timeout_s;
  logic        anyErr_s;
  logic [1:0]  errCode_s;
  logic        reqHold_s;

  // Pacer and fault detection
  always_comb begin
    curHalf_s   = addr_r[7];
    pacerRun_s  = primed_r && enable && (state_r != ERROR) && !error_r;
    terminal_s  = pacerRun_s && (paceCnt_r == (READ_INTERVAL - 16'd1));
    readOk_s    = terminal_s && halfReady_r[curHalf_s];
    underrun_s  = terminal_s && !halfReady_r[curHalf_s];
    leaveHalf_s = readOk_s && (addr_r[6:0] == 7'h7F);
    // A fill completing on the very half being vacated this cycle is illegal.
    doneOk_s    = fillDone && (state_r == WAIT_DONE) &&
                  !(leaveHalf_s && (curHalf_s == sel_r));
    overrun_s   = fillDone && !doneOk_s;
    timeout_s   = ((state_r == REQ) || (state_r == WAIT_DONE)) &&
                  (timer_r == (REQ_TIMEOUT - 16'd1));
    anyErr_s    = underrun_s || overrun_s || timeout_s;
    if (overrun_s) begin
      errCode_s = CODE_OVERRUN;
    end else if (underrun_s) begin
      errCode_s = CODE_UNDERRUN;
    end else if (timeout_s) begin
      errCode_s = CODE_TIMEOUT;
    end else begin
      errCode_s = 2'b00;
    end
  end

  // Half bookkeeping: consumption and refill completion may hit different halves together
  always_comb begin
    halfReadyNext_s   = halfReady_r;
    pendingFillNext_s = pendingFill_r;
    if (leaveHalf_s) begin
      halfReadyNext_s[curHalf_s]   = 1'b0;
      pendingFillNext_s[curHalf_s] = 1'b1;
    end else begin
      halfReadyNext_s[curHalf_s]   = halfReady_r[curHalf_s];
    end
    if (doneOk_s) begin
      halfReadyNext_s[sel_r]   = 1'b1;
      pendingFillNext_s[sel_r] = 1'b0;
    end else begin
      pendingFillNext_s[sel_r] = pendingFillNext_s[sel_r];
    end
  end

  // Request FSM next state and handshake timer
  always_comb begin
    stateNext_s = state_r;
    selNext_s   = sel_r;
    case (state_r)
      IDLE: begin
        if (enable && (pendingFill_r != 2'b00)) begin
          stateNext_s = REQ;
          selNext_s   = ~pendingFill_r[0];
        end else begin
          stateNext_s = IDLE;
        end
      end
      REQ: begin
        if (msgToFillBufferWasReceived) begin
          stateNext_s = WAIT_DONE;
        end else begin
          stateNext_s = REQ;
        end
      end
      WAIT_DONE: begin
        if (doneOk_s) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = WAIT_DONE;
        end
      end
      ERROR:   stateNext_s = ERROR;
      default: stateNext_s = ERROR;
    endcase
    if (anyErr_s) begin
      stateNext_s = ERROR;
    end else begin
      stateNext_s = stateNext_s;
    end

    if (stateNext_s != state_r) begin
      timerNext_s = 16'd0;
    end else if ((state_r == REQ) || (state_r == WAIT_DONE)) begin
      timerNext_s = timer_r + 16'd1;
    end else begin
      timerNext_s = 16'd0;
    end

    reqHold_s = (state_r == REQ) && (stateNext_s == REQ);
  end

  // FSM, bookkeeping and timer registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r       <= IDLE;
      sel_r         <= 1'b0;
      halfReady_r   <= 2'b00;
      pendingFill_r <= 2'b11;
      primed_r      <= 1'b0;
      timer_r       <= 16'd0;
    end else begin
      state_r       <= stateNext_s;
      sel_r         <= selNext_s;
      halfReady_r   <= halfReadyNext_s;
      pendingFill_r <= pendingFillNext_s;
      primed_r      <= primed_r | halfReadyNext_s[0];
      timer_r       <= timerNext_s;
    end
  end

  // Read pacing, address walk and registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      paceCnt_r    <= 16'd0;
      addr_r       <= 8'h00;
      wordOut_r    <= 32'h0000_0000;
      wordValid_r  <= 1'b0;
      fillBuffer_r <= 1'b0;
      fillHalf_r   <= 1'b0;
      error_r      <= 1'b0;
      errorCode_r  <= 2'b00;
    end else begin
      if (readOk_s) begin
        paceCnt_r <= 16'd0;
        addr_r    <= addr_r + 8'd1;
        wordOut_r <= dataAtBuffer;
      end else if (pacerRun_s && !terminal_s) begin
        paceCnt_r <= paceCnt_r + 16'd1;
      end else begin
        paceCnt_r <= paceCnt_r;
      end
      wordValid_r  <= readOk_s;
      fillBuffer_r <= reqHold_s;
      fillHalf_r   <= reqHold_s ? sel_r : 1'b0;
      if (!error_r && anyErr_s) begin
        error_r     <= 1'b1;
        errorCode_r <= errCode_s;
      end else begin
        error_r     <= error_r;
        errorCode_r <= errorCode_r;
      end
    end
  end

  assign addressAtBuffer = addr_r;
  assign wordOut         = wordOut_r;
  assign wordValid       = wordValid_r;
  assign fillBuffer      = fillBuffer_r;
  assign fillHalf        = fillHalf_r;
  assign error           = error_r;
  assign errorCode       = errorCode_r;

endmodule

// File: tb/tb_half_buffer_fill_scheduler.sv
// Directed bench: dutA (short read interval, long timeout) covers pacing, refill, underrun,
// overrun and async reset; dutB (16-cycle timeout) shares the stimulus and covers timeout.
module tb_half_buffer_fill_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetN, enable, ack, fillDone;
  logic [7:0]  addrA, addrB;
  logic [31:0] dataA, dataB, wordOutA, wordOutB;
  logic        wordValidA, wordValidB, fillBufferA, fillBufferB;
  logic        fillHalfA, fillHalfB, errorA, errorB;
  logic [1:0]  errorCodeA, errorCodeB;

  int testCount = 0;
  int failCount = 0;

  function automatic logic [31:0] dataOf(input logic [7:0] a);
    return {a, ~a, a ^ 8'h3C, 8'hC3};
  endfunction

  assign dataA = dataOf(addrA);
  assign dataB = dataOf(addrB);

  half_buffer_fill_scheduler #(.READ_INTERVAL(16'd4), .REQ_TIMEOUT(16'h4000)) dutA (
    .clock(clock), .resetN(resetN), .enable(enable),
    .addressAtBuffer(addrA), .dataAtBuffer(dataA),
    .wordOut(wordOutA), .wordValid(wordValidA),
    .fillBuffer(fillBufferA), .fillHalf(fillHalfA),
    .msgToFillBufferWasReceived(ack), .fillDone(fillDone),
    .error(errorA), .errorCode(errorCodeA)
  );

  half_buffer_fill_scheduler #(.READ_INTERVAL(16'd4), .REQ_TIMEOUT(16'd16)) dutB (
    .clock(clock), .resetN(resetN), .enable(enable),
    .addressAtBuffer(addrB), .dataAtBuffer(dataB),
    .wordOut(wordOutB), .wordValid(wordValidB),
    .fillBuffer(fillBufferB), .fillHalf(fillHalfB),
    .msgToFillBufferWasReceived(ack), .fillDone(fillDone),
    .error(errorB), .errorCode(errorCodeB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkAllZeroA(input string tag);
    checkVal({tag, "_addr"},  {24'd0, addrA}, 32'd0);
    checkVal({tag, "_word"},  wordOutA, 32'd0);
    checkVal({tag, "_valid"}, {31'd0, wordValidA}, 32'd0);
    checkVal({tag, "_fb"},    {31'd0, fillBufferA}, 32'd0);
    checkVal({tag, "_half"},  {31'd0, fillHalfA}, 32'd0);
    checkVal({tag, "_err"},   {31'd0, errorA}, 32'd0);
    checkVal({tag, "_code"},  {30'd0, errorCodeA}, 32'd0);
  endtask

  task automatic waitAddrA(input string tag, input logic [7:0] target, input int limit);
    int n = 0;
    while (addrA !== target && n < limit) begin
      tick(1);
      n++;
    end
    checkVal(tag, {24'd0, addrA}, {24'd0, target});
  endtask

  // Entered at a negedge with resetN low; releases reset and fills both halves.
  task automatic primeSeq(input string tag);
    resetN = 1'b1; enable = 1'b1; ack = 1'b0; fillDone = 1'b0;
    tick(1);
    checkVal({tag, "_fb_early"}, {31'd0, fillBufferA}, 32'd0);
    tick(1);
    checkVal({tag, "_fb0"},   {31'd0, fillBufferA}, 32'd1);
    checkVal({tag, "_half0"}, {31'd0, fillHalfA}, 32'd0);
    checkVal({tag, "_fbB"},   {31'd0, fillBufferB}, 32'd1);
    ack = 1'b1;
    tick(1);
    checkVal({tag, "_ackdrop"}, {31'd0, fillBufferA}, 32'd0);
    ack = 1'b0; fillDone = 1'b1;
    tick(1);
    fillDone = 1'b0;
    tick(2);
    checkVal({tag, "_fb1"},   {31'd0, fillBufferA}, 32'd1);
    checkVal({tag, "_half1"}, {31'd0, fillHalfA}, 32'd1);
    ack = 1'b1;
    tick(1);
    checkVal({tag, "_novalid"}, {31'd0, wordValidA}, 32'd0);
    ack = 1'b0; fillDone = 1'b1;
    tick(1);
    fillDone = 1'b0;
    checkVal({tag, "_valid0"}, {31'd0, wordValidA}, 32'd1);
    checkVal({tag, "_word0"},  wordOutA, dataOf(8'h00));
    checkVal({tag, "_addr1"},  {24'd0, addrA}, 32'd1);
    checkVal({tag, "_fbidle"}, {31'd0, fillBufferA}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkVal({tag, "_gap"}, {31'd0, wordValidA}, 32'd0);
    end
    tick(1);
    checkVal({tag, "_valid1"}, {31'd0, wordValidA}, 32'd1);
    checkVal({tag, "_word1"},  wordOutA, dataOf(8'h01));
    checkVal({tag, "_addr2"},  {24'd0, addrA}, 32'd2);
  endtask

  initial begin
    int vc;
    int n;
    resetN = 1'b0; enable = 1'b0; ack = 1'b0; fillDone = 1'b0;
    tick(2);
    checkAllZeroA("rst");

    primeSeq("prime");

    // pause holds the pacer; resume reads four cycles later
    enable = 1'b0;
    tick(10);
    checkVal("pause_addr", {24'd0, addrA}, 32'd2);
    checkVal("pause_valid", {31'd0, wordValidA}, 32'd0);
    enable = 1'b1;
    tick(4);
    checkVal("resume_valid", {31'd0, wordValidA}, 32'd1);
    checkVal("resume_word", wordOutA, dataOf(8'h02));
    checkVal("resume_addr", {24'd0, addrA}, 32'd3);

    // 7F -> 80 boundary
    waitAddrA("reach_80", 8'h80, 1000);
    checkVal("word_7f", wordOutA, dataOf(8'h7F));
    checkVal("b0_fb_pre", {31'd0, fillBufferA}, 32'd0);
    tick(2);
    checkVal("b0_fb", {31'd0, fillBufferA}, 32'd1);
    checkVal("b0_half", {31'd0, fillHalfA}, 32'd0);
    ack = 1'b1; tick(1); ack = 1'b0; fillDone = 1'b1; tick(1); fillDone = 1'b0;

    // FF -> 00 wrap, then hold WAIT_DONE and reset asynchronously at 0x45
    waitAddrA("reach_00", 8'h00, 1000);
    checkVal("word_ff", wordOutA, dataOf(8'hFF));
    tick(2);
    checkVal("b1_fb", {31'd0, fillBufferA}, 32'd1);
    checkVal("b1_half", {31'd0, fillHalfA}, 32'd1);
    ack = 1'b1; tick(1); ack = 1'b0;
    waitAddrA("reach_45", 8'h45, 1000);
    #2 resetN = 1'b0;
    #1 checkAllZeroA("arst");
    @(negedge clock);
    primeSeq("reprime");

    // underrun: half 0 refill never completes
    waitAddrA("ur_reach_80", 8'h80, 1000);
    tick(2);
    checkVal("ur_fb", {31'd0, fillBufferA}, 32'd1);
    checkVal("ur_half", {31'd0, fillHalfA}, 32'd0);
    ack = 1'b1; tick(1); ack = 1'b0;
    n = 0;
    while (errorA !== 1'b1 && n < 1500) begin
      tick(1);
      n++;
    end
    checkVal("ur_err", {31'd0, errorA}, 32'd1);
    checkVal("ur_code", {30'd0, errorCodeA}, 32'd1);
    checkVal("ur_addr", {24'd0, addrA}, 32'd0);
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (wordValidA === 1'b1) vc++;
    end
    checkVal("ur_novalid", vc, 32'd0);
    checkVal("ur_addr_hold", {24'd0, addrA}, 32'd0);

    // timeout on dutB: ack withheld
    resetN = 1'b0; tick(1);
    resetN = 1'b1; enable = 1'b1; ack = 1'b0; fillDone = 1'b0;
    tick(2);
    checkVal("to_fb", {31'd0, fillBufferB}, 32'd1);
    tick(14);
    checkVal("to_err_early", {31'd0, errorB}, 32'd0);
    tick(1);
    checkVal("to_err", {31'd0, errorB}, 32'd1);
    checkVal("to_code", {30'd0, errorCodeB}, 32'd3);
    checkVal("to_fb_off", {31'd0, fillBufferB}, 32'd0);
    fillDone = 1'b1; tick(1); fillDone = 1'b0;
    checkVal("to_first_wins", {30'd0, errorCodeB}, 32'd3);

    // spurious fillDone in IDLE on dutA
    resetN = 1'b0; tick(1);
    resetN = 1'b1; enable = 1'b0;
    tick(2);
    checkVal("ov_pre", {31'd0, errorA}, 32'd0);
    fillDone = 1'b1; tick(1); fillDone = 1'b0;
    checkVal("ov_err", {31'd0, errorA}, 32'd1);
    checkVal("ov_code", {30'd0, errorCodeA}, 32'd2);
    checkVal("ov_fb", {31'd0, fillBufferA}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
